// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: fetch and data share one single-port synchronous memory, data has priority.
// Define MEM_ARB_STARVE_GUARD_EN to hand a tie to fetch after STARVE_MAX consecutive data wins.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             owner_d;
    logic             owner_we;
    logic             arb;
    logic             resp;
    logic             fetch_turn;
    logic             d_win;
    logic             if_win;

    // Arbitration is open when idle or in the response cycle; held off while reset is asserted.
    assign arb  = reset_n && ((state == IDLE) || (cnt == '0));
    assign resp = (state == WAIT) && (cnt == '0);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int ST_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [ST_W-1:0] starve;

    assign fetch_turn = (starve >= ST_W'(STARVE_MAX));

    // Counts consecutive data wins over a waiting fetch; any fetch grant or idle fetch clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve <= '0;
        end else if (!if_req || if_gnt) begin
            starve <= '0;
        end else if (d_gnt && !fetch_turn) begin
            starve <= starve + ST_W'(1);
        end
    end
`else
    assign fetch_turn = 1'b0;
`endif

    assign d_win  = d_req && !(if_req && fetch_turn);
    assign if_win = if_req && !d_win;

    assign if_gnt    = arb && if_win;
    assign d_gnt     = arb && d_win;
    assign mem_en    = if_gnt || d_gnt;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata = d_gnt ? d_wdata : '0;

    assign if_rvalid = resp && !owner_d;
    assign d_rvalid  = resp && owner_d;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !owner_we) ? mem_rdata : '0;
    assign busy      = (state == WAIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            owner_d  <= 1'b0;
            owner_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        state    <= WAIT;
                        cnt      <= CNT_W'(MEM_LAT - 1);
                        owner_d  <= d_gnt;
                        owner_we <= d_gnt && d_we;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (mem_en) begin
                        cnt      <= CNT_W'(MEM_LAT - 1);
                        owner_d  <= d_gnt;
                        owner_we <= d_gnt && d_we;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus random traffic against a timestamp-based model.
// Honours MEM_ARB_STARVE_GUARD_EN the same way the design does.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0, mem_addr;
    logic [DW-1:0] d_wdata = '0, mem_wdata, mem_rdata, if_rdata, d_rdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;

    logic          b_if_req = 1'b0;
    logic [AW-1:0] b_if_addr = '0, b_mem_addr;
    logic [DW-1:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
    logic          b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut_fast (
        .clock(clock), .reset_n(reset_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Behavioural memory: word array whose reset content is address + 3, read data delayed by LAT.
    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] pipe [LAT];
    logic [DW-1:0] b_pipe;

    assign mem_rdata   = pipe[LAT-1];
    assign b_mem_rdata = b_pipe;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'(i * 4 + 3);
    end

    always @(posedge clock) begin
        pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[9:2]] : '0;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        if (mem_en && mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
        b_pipe <= (b_mem_en && !b_mem_we) ? b_mem_addr + 32'h3 : '0;
    end

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        return mem_arr[a[9:2]];
    endfunction

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: at most one outstanding transaction, tracked by grant and due timestamps.
    logic          m_pend = 1'b0;
    int            m_grant_cyc = 0;
    int            m_due = 0;
    logic          m_owner_d = 1'b0;
    logic [DW-1:0] m_pend_data = '0;
    int            m_starve = 0;
    logic          m_if_gnt = 1'b0;
    logic          m_d_gnt = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic modelReset();
        m_pend   = 1'b0;
        m_starve = 0;
        cyc      = 0;
    endtask

    task automatic applyStimulus(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dwe,
                                 input logic [AW-1:0] da, input logic [DW-1:0] dwd);
        logic resp, can_arb, fetch_turn, exp_busy;
        @(negedge clock);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        #1;
        resp    = m_pend && (m_due == cyc);
        can_arb = !m_pend || resp;
`ifdef MEM_ARB_STARVE_GUARD_EN
        fetch_turn = (m_starve >= SMAX);
`else
        fetch_turn = 1'b0;
`endif
        m_d_gnt  = can_arb && dr && !(ir && fetch_turn);
        m_if_gnt = can_arb && ir && !m_d_gnt;
        exp_busy = m_pend && (cyc > m_grant_cyc);

        checkOutput("if_gnt", if_gnt, m_if_gnt);
        checkOutput("d_gnt", d_gnt, m_d_gnt);
        checkOutput("mem_en", mem_en, m_if_gnt || m_d_gnt);
        checkOutput("mem_we", mem_we, m_d_gnt && dwe);
        checkOutput("mem_addr", mem_addr, m_d_gnt ? da : (m_if_gnt ? ia : '0));
        if (!m_if_gnt) checkOutput("mem_wdata", mem_wdata, m_d_gnt ? dwd : '0);
        checkOutput("if_rvalid", if_rvalid, resp && !m_owner_d);
        checkOutput("if_rdata", if_rdata, (resp && !m_owner_d) ? m_pend_data : '0);
        checkOutput("d_rvalid", d_rvalid, resp && m_owner_d);
        checkOutput("d_rdata", d_rdata, (resp && m_owner_d) ? m_pend_data : '0);
        checkOutput("busy", busy, exp_busy);

        if (resp) m_pend = 1'b0;
        if (m_d_gnt || m_if_gnt) begin
            m_pend      = 1'b1;
            m_grant_cyc = cyc;
            m_due       = cyc + LAT;
            m_owner_d   = m_d_gnt;
            m_pend_data = m_d_gnt ? (dwe ? '0 : mem_read(da)) : mem_read(ia);
        end
        if (!ir || m_if_gnt) m_starve = 0;
        else if (m_d_gnt && m_starve < SMAX) m_starve++;
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, {if_gnt, d_gnt}, 32'h0);
        checkOutput({tag, "_mem"}, {mem_en, mem_we}, 32'h0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, "_rvalid"}, {if_rvalid, d_rvalid}, 32'h0);
        checkOutput({tag, "_rdata"}, if_rdata | d_rdata, 32'h0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int d_grants, if_grants, first_if;
        logic ifp, dp, dwe;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] dw;

        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        checkAllZero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        modelReset();

        $display("[TB] single fetch");
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
        checkOutput("plan_fetch_gnt", {if_gnt, mem_en, mem_we}, 32'b110);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("plan_fetch_rdata", if_rdata, 32'h0000_0013);

        $display("[TB] simultaneous requests");
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h30, '0);
        checkOutput("plan_sim_d_gnt", {d_gnt, if_gnt}, 32'b10);
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, '0, '0);
        checkOutput("plan_sim_c2", {d_rvalid, if_gnt}, 32'b11);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("plan_sim_if_rvalid", if_rvalid, 1'b1);

        $display("[TB] store then load back");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        checkOutput("plan_store_wdata", mem_wdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("plan_store_ack", {d_rvalid, d_rdata}, {1'b1, 32'h0});
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h40, '0);
        idleCycles(2);
        checkOutput("plan_load_back", d_rdata, 32'hDEAD_BEEF);

        $display("[TB] starvation");
        d_grants = 0; if_grants = 0; first_if = -1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0);
            if (if_gnt) begin
                if (first_if < 0) first_if = d_grants;
                if_grants++;
            end
            if (d_gnt) d_grants++;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        checkOutput("starve_data_before_fetch", first_if, SMAX);
`else
        checkOutput("strict_fetch_grants", if_grants, 0);
`endif
        idleCycles(3);

        $display("[TB] reset mid-transaction");
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, '0, '0);
        @(negedge clock);
        if_req = 1'b0;
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clock); #1;
        checkAllZero("midreset_hold");
        @(negedge clock);
        reset_n = 1'b1;
        modelReset();
        applyStimulus(1'b1, 32'hC0, 1'b0, 1'b0, '0, '0);
        checkOutput("reset_regrant", if_gnt, 1'b1);
        idleCycles(3);

        $display("[TB] random traffic");
        ifp = 1'b0; dp = 1'b0; dwe = 1'b0; ia = '0; da = '0; dw = '0;
        for (int i = 0; i < 400; i++) begin
            if (!ifp) begin
                if ($urandom_range(0, 1) == 1) begin
                    ifp = 1'b1;
                    ia  = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
                end
            end else if ($urandom_range(0, 9) == 0) begin
                ifp = 1'b0;
            end
            if (!dp) begin
                if ($urandom_range(0, 1) == 1) begin
                    dp  = 1'b1;
                    dwe = 1'($urandom_range(0, 1));
                    da  = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
                    dw  = $urandom;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                dp = 1'b0;
            end
            applyStimulus(ifp, ia, dp, dwe, da, dw);
            if (m_if_gnt) ifp = 1'b0;
            if (m_d_gnt) dp = 1'b0;
        end
        idleCycles(4);

        $display("[TB] back-to-back with single-cycle latency");
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            b_if_req  = 1'b1;
            b_if_addr = 32'(k * 4);
            #1;
            checkOutput("b2b_gnt", b_if_gnt, 1'b1);
            checkOutput("b2b_addr", b_mem_addr, 32'(k * 4));
            checkOutput("b2b_rvalid", b_if_rvalid, k > 0);
            if (k > 0) checkOutput("b2b_rdata", b_if_rdata, 32'((k - 1) * 4 + 3));
        end
        @(negedge clock);
        b_if_req = 1'b0;
        #1;
        checkOutput("b2b_last", {b_if_gnt, b_if_rvalid}, 32'b01);
        checkOutput("b2b_last_rdata", b_if_rdata, 32'h0000_000B);
        @(negedge clock); #1;
        checkOutput("b2b_idle", {b_busy, b_if_rvalid, b_mem_en}, 32'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the pipeline's instruction-fetch stage and its memory stage, replacing the split instruction/data arrays with one unified memory port. Accepts one transaction at a time, gives the data side fixed priority, and can bound instruction-fetch starvation. Sits between the CPU pipeline and the unified memory. Requesters stall on a missing grant or response.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 2, cycles from the `mem_en` cycle to valid `mem_rdata`; legal range ≥1.
- `STARVE_MAX`, 4, consecutive data wins tolerated while fetch waits.

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch read request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch read data valid, one-cycle pulse.
- `if_rdata`  out  DATA_W  fetch read data.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  load data valid or store acknowledgement, one-cycle pulse.
- `d_rdata`  out  DATA_W  load data; 0 for a store.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid `MEM_LAT` cycles after `mem_en`.
- `busy`  out  1  transaction outstanding.

## Operation
- The FSM has two states.
  - `IDLE`: accepts requests.
  - `WAIT`: holds a down-counter `cnt` (width clog2(MEM_LAT)+1) and an owner flag (IF or D).
- **Arbitration cycle:** any cycle in `IDLE`, or any cycle in `WAIT` with `cnt==0`.
  - Grant data when only `d_req` is high, or when both are high and `starve < STARVE_MAX`.
  - Grant fetch when only `if_req` is high, or when both are high and `starve == STARVE_MAX`.
- **Grant cycle** (combinational, same cycle as the request):
  - Assert the winner's `gnt` and `mem_en`.
  - Drive `mem_addr` from the winner's address.
  - Drive `mem_we`/`mem_wdata` from `d_we`/`d_wdata` when data wins; drive `mem_we` = 0 when fetch wins.
  - Next state: `WAIT`, with `cnt ← MEM_LAT-1` and the owner flag set to the winner.
- **Response:**
  - In `WAIT` with `cnt==0`, assert the owner's `rvalid`.
  - `rdata` = `mem_rdata` (combinational) for a read; `d_rdata` = 0 for a store.
  - If there is no new grant in that cycle, go to `IDLE`.
- In `WAIT` with `cnt>0`, decrement `cnt`. No grants are given.
- `busy` = (state == `WAIT`).
- When not strobing, memory outputs and non-owner `rdata` are driven to 0.
- **Starvation counter `starve`:**
  - Increments, saturating at `STARVE_MAX`, when both requests are present and data wins.
  - Clears when fetch is granted, or in any cycle with `if_req`=0.
- A requester may drop `req` before its grant; it then receives no grant and no response.
- `req` going low after the grant has no effect on the outstanding transaction.

## Timing
- For a grant in cycle T, `rvalid` is asserted in cycle T+MEM_LAT.
- A new grant is possible in cycle T+MEM_LAT, which gives a throughput of one transaction per `MEM_LAT` cycles.
- With `MEM_LAT=1`, back-to-back grants are possible every cycle.
- Reset values:
  - state `IDLE`, `cnt`=0, owner = IF, `starve`=0.
  - All outputs 0.
- Reset asserted mid-transaction abandons it. No `rvalid` follows.
- `gnt`, `mem_*` and `rdata` are combinational from inputs and state. `rvalid` is combinational from state only.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: starvation guard active as described.
- Undefined: `starve` logic is removed, and data always wins simultaneous requests (strict priority). `STARVE_MAX` is ignored.

## Test plan
- **Single fetch** (MEM_LAT=2): `if_req`, `if_addr`=0x10 at cycle 0.
  - Cycle 0: `if_gnt`=1, `mem_en`=1, `mem_addr`=0x10, `mem_we`=0.
  - Cycle 2: `if_rvalid`=1, `if_rdata`=0x00000013, with memory returning 0x00000013.
- **Simultaneous requests** at cycle 0:
  - `d_gnt` at cycle 0, `d_rvalid` at cycle 2.
  - `if_gnt` at cycle 2, `if_rvalid` at cycle 4.
- **Store:** `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEADBEEF.
  - Cycle 0: `mem_we`=1, `mem_wdata`=0xDEADBEEF.
  - Cycle 2: `d_rvalid`=1, `d_rdata`=0.
- **Starvation** (STARVE_MAX=4), both requests held continuously:
  - Macro defined: 4 data grants, then the 5th grant goes to fetch.
  - Macro undefined: fetch is never granted.
- **Reset mid-transaction:** `reset_n` low during cycle 1 of a fetch.
  - No `if_rvalid`, `busy`=0, all outputs 0.
  - A request after reset release is granted immediately.
- **Back-to-back** (MEM_LAT=1): fetch reads at 0x0, 0x4, 0x8 on consecutive cycles.
  - Grants in cycles 0/1/2; `rvalid` in cycles 1/2/3 with matching data.
